bcd_serial_subtractor: RTL
==========================

# bcd_serial_subtractor

Digit-serial multi-digit BCD subtractor. Computes |A − B| of two packed-BCD operands one digit per clock, LSD first, with a sign flag, using a start/ready/done handshake. It is the inverse-direction companion to the team's combinational BCD adder. Its intended use is in counters and calculators that must decrement or compare decimal values without binary conversion.

## Interface
- DIGITS, 4: number of BCD digits per operand (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only while ready=1
- a  in  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0]
- b  in  4*DIGITS  subtrahend, packed BCD
- ready  out  1  high in IDLE only
- done  out  1  single-cycle pulse when results update
- diff  out  4*DIGITS  packed BCD magnitude |a−b|
- neg  out  1  1 when a<b
- invalid  out  1  1 when any input nibble of a or b was >9

## Operation
- States: IDLE, SUB, NEG, DONE.
- IDLE: ready=1. A rising edge with start=1 captures a and b into working registers, clears the digit counter and borrow, and checks every nibble.
  - Any nibble >9: go to DONE; result is diff=0, neg=0, invalid=1.
  - Otherwise go to SUB.
- SUB: each cycle processes digit i=counter.
  - t = a_i − b_i − borrow.
  - If t<0: d_i = t+10, borrow←1. Else d_i = t, borrow←0.
  - d_i is written into the working result.
  - When counter=DIGITS−1: go to NEG if the final borrow=1, else go to DONE.
- NEG: reuses the same datapath with minuend 0 and subtrahend = working result. Borrow is cleared on entry. This produces the ten's complement (the magnitude), one digit per cycle. After DIGITS cycles go to DONE with neg=1.
- DONE: lasts exactly one cycle. done=1, ready=0. diff/neg/invalid are loaded from working state at the edge entering DONE. Next state is IDLE.
- diff/neg/invalid hold stable from one DONE to the next. They do not change during a later SUB/NEG.
- start outside IDLE is ignored. There is no queueing.
- a==b yields diff=0, neg=0. A negative zero is impossible.
- Reset (any time, including mid-SUB/NEG): state←IDLE, ready=1, done=0, diff=0, neg=0, invalid=0, working registers cleared. An aborted operation produces no done.

## Timing
- Edge 0 samples start.
- a≥b: SUB occupies cycles 1..DIGITS; done is high in cycle DIGITS+1.
- a<b: NEG occupies cycles DIGITS+1..2·DIGITS; done is high in cycle 2·DIGITS+1.
- Invalid input: done is high in cycle 1.
- ready returns to 1 in the cycle after done. Minimum start-to-start spacing is latency+1.
- Borrow and d_i are combinational from registered operands; the per-cycle path covers one digit only.

## Structure
- Shared package bcd_pkg:
  - DIGIT_W=4, BCD_MAX=9.
  - State enum {IDLE, SUB, NEG, DONE}.
  - Function is_bcd(nibble).
- Sub-module bcd_digit_sub:
  - Combinational single-digit a, b, bin → d, bout.
  - Instantiated once and shared by SUB and NEG through an operand mux.
- Digit counter width is clog2(DIGITS), minimum 1. Operands are shifted right one nibble per cycle; the result is shifted in at the MSD.

## Test plan
- DIGITS=4:
  - a=0x5432, b=0x1234 → diff=0x4198, neg=0, invalid=0; done in cycle 5 only.
  - a=0x1000, b=0x0001 → diff=0x0999, neg=0 (full borrow ripple).
  - a=0x0012, b=0x0345 → diff=0x0333, neg=1; done in cycle 9; ready=0 for cycles 1–9.
  - a=0x9999, b=0x9999, then a=0x0000, b=0x0000 → both give diff=0x0000, neg=0; outputs hold between operations.
  - a=0x12A4, b=0x0001 → invalid=1, diff=0, neg=0, done in cycle 1. A following valid op clears invalid.
  - Start 0x0012−0x0345, pulse start again in cycle 3 (ignored), assert rst in cycle 6 → no done; ready=1, diff=0, neg=0 immediately on rst.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, FSM state type and nibble check for the BCD subtractor
// Contents:
//   DIGIT_W  bits per BCD digit
//   BCD_MAX  largest legal digit value
//   state_t  sequencer states
//   is_bcd   1 when a nibble holds a legal decimal digit
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] nibble);
    return nibble <= DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// rtl/bcd_digit_sub.sv - combinational single-digit BCD subtract with borrow
// Ports:
//   a     in   minuend digit
//   b     in   subtrahend digit
//   bin   in   borrow in
//   d     out  result digit, 0..9 for legal inputs
//   bout  out  borrow out
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  // One extra bit holds the sign of a - b - bin (range -10..9).
  logic [DIGIT_W:0] t;

  always_comb begin
    t    = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bin};
    d    = t[DIGIT_W-1:0];
    bout = 1'b0;
    if (t[DIGIT_W]) begin
      // Low bits hold t+16 modulo 16; adding 10 gives t+10 modulo 16.
      d    = t[DIGIT_W-1:0] + DIGIT_W'(10);
      bout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// rtl/bcd_serial_subtractor.sv - digit-serial |a-b| on packed BCD, LSD first, with sign flag
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   start    in   request, sampled only while ready=1
//   a, b     in   packed BCD minuend / subtrahend, digit 0 in bits [3:0]
//   ready    out  high in IDLE only
//   done     out  one-cycle pulse when diff/neg/invalid have just been updated
//   diff     out  packed BCD magnitude |a-b|
//   neg      out  1 when a<b
//   invalid  out  1 when any nibble of a or b was above 9
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIGITS*DIGIT_W-1:0] a,
  input  logic [DIGITS*DIGIT_W-1:0] b,
  output logic                      ready,
  output logic                      done,
  output logic [DIGITS*DIGIT_W-1:0] diff,
  output logic                      neg,
  output logic                      invalid
);

  localparam int W  = DIGITS * DIGIT_W;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t state, state_nxt;

  logic [W-1:0]       op_a, op_b, res, res_shift;
  logic               borrow;
  logic [CW-1:0]      cnt;
  logic               last_digit;
  logic               inputs_ok;
  logic [DIGIT_W-1:0] mux_a, mux_b, d;
  logic               bout;

  assign last_digit = (cnt == LAST);

  always_comb begin
    inputs_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(a[i*DIGIT_W +: DIGIT_W]) || !is_bcd(b[i*DIGIT_W +: DIGIT_W])) begin
        inputs_ok = 1'b0;
      end
    end
  end

  // NEG pass computes 0 - res, i.e. the ten's complement of the SUB result,
  // reusing the single digit slice.
  always_comb begin
    mux_a = op_a[DIGIT_W-1:0];
    mux_b = op_b[DIGIT_W-1:0];
    if (state == NEG) begin
      mux_a = '0;
      mux_b = res[DIGIT_W-1:0];
    end
  end

  bcd_digit_sub u_digit (
    .a    (mux_a),
    .b    (mux_b),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  // res acts as a rotating buffer: the low digit is consumed (in NEG) while
  // the new digit enters at the MSD, so after DIGITS shifts order is restored.
  assign res_shift = (res >> DIGIT_W) | ({{(W-DIGIT_W){1'b0}}, d} << (W - DIGIT_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = inputs_ok ? SUB : DONE;
        end
      end
      SUB: begin
        if (last_digit) begin
          state_nxt = bout ? NEG : DONE;
        end
      end
      NEG: begin
        if (last_digit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      res     <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      diff    <= '0;
      neg     <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= a;
            op_b   <= b;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            if (!inputs_ok) begin
              diff    <= '0;
              neg     <= 1'b0;
              invalid <= 1'b1;
            end
          end
        end
        SUB: begin
          op_a   <= op_a >> DIGIT_W;
          op_b   <= op_b >> DIGIT_W;
          res    <= res_shift;
          borrow <= bout;
          cnt    <= cnt + CW'(1);
          if (last_digit) begin
            // Both exits restart the count; NEG must also start borrow-free.
            cnt    <= '0;
            borrow <= 1'b0;
            if (!bout) begin
              diff    <= res_shift;
              neg     <= 1'b0;
              invalid <= 1'b0;
            end
          end
        end
        NEG: begin
          res    <= res_shift;
          borrow <= bout;
          cnt    <= cnt + CW'(1);
          if (last_digit) begin
            cnt     <= '0;
            borrow  <= 1'b0;
            diff    <= res_shift;
            neg     <= 1'b1;
            invalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
